// File: rtl/node_mac_sequencer_pkg.sv
// Shared types and constants for the neuron MAC sequencer.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package node_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] ZERO = 32'h0000_0000;
  localparam logic [31:0] ONE  = 32'h3F80_0000;

  // Weight table; evaluations wider than the table reuse it modulo its length.
  localparam int W_TABLE_LEN = 16;
  localparam logic [31:0] W_TABLE [W_TABLE_LEN] = '{
    32'h3F000000, 32'h3F46BDCF, 32'hBF400000, 32'hBE7964A1,
    32'h3FC00000, 32'h3E800000, 32'hBF800000, 32'h3F59999A,
    32'h3DCCCCCD, 32'hC0000000, 32'h3F200000, 32'hBEAAAAAB,
    32'h3F800000, 32'h3E4CCCCD, 32'hBF000000, 32'h40400000
  };

  function automatic logic [31:0] weight_of(input int unsigned idx);
    return W_TABLE[4'(idx % W_TABLE_LEN)];
  endfunction

  // Sign bit set (including -0.0 and negative NaN) clamps to +0.0.
  function automatic logic [31:0] relu(input logic [31:0] x);
    return x[31] ? ZERO : x;
  endfunction

endpackage

// File: rtl/float_adder.sv
// IEEE-754 single add, round-to-nearest-even, subnormals flushed to zero.
// Latency: combinational.
// Backpressure: none; debug outputs expose pre-round value, alignment shift and carry.
module float_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic [31:0] Out_test,
  output logic [7:0]  shift,
  output logic        c_out
);

  logic [31:0] big, sml;
  logic [7:0]  d;
  logic [4:0]  dcap, lz;
  logic [50:0] sh;
  logic [26:0] bm, sm, n;
  logic [27:0] sum;
  logic [24:0] rm;
  logic [22:0] frac;
  logic        rnd, a_zero, b_zero, a_spec, b_spec, a_nan, b_nan;
  int          e;

  // Align smaller operand with guard/round/sticky, add or subtract, normalise, round
  always_comb begin
    big  = (a[30:23] == b[30:23] && a[22:0] == b[22:0]) ? a :
           ((a[30:0] >= b[30:0]) ? a : b);
    sml  = (a[30:0] >= b[30:0]) ? b : a;
    d    = big[30:23] - sml[30:23];
    // Beyond 26 places the small operand only contributes sticky.
    dcap = (d > 8'd26) ? 5'd26 : d[4:0];
    sh   = {1'b1, sml[22:0], 27'd0} >> dcap;
    sm   = {sh[50:25], |sh[24:0]};
    bm   = {1'b1, big[22:0], 3'b000};
    sum  = (big[31] ^ sml[31]) ? ({1'b0, bm} - {1'b0, sm}) : ({1'b0, bm} + {1'b0, sm});
    lz   = '0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = int'(big[30:23]) + 1;
    end else begin
      n = sum[26:0] << lz;
      e = int'(big[30:23]) - int'(lz);
    end
    rnd = n[2] & (n[1] | n[0] | n[3]);
    rm  = {1'b0, n[26:3]} + 25'(rnd);
    if (rm[24]) begin
      e    = e + 1;
      frac = rm[23:1];
    end else begin
      frac = rm[22:0];
    end
    Out_test = {big[31], e[7:0], n[25:3]};
    shift    = d;
    c_out    = sum[27];

    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_spec = (a[30:23] == 8'hFF);
    b_spec = (b[30:23] == 8'hFF);
    a_nan  = a_spec && (a[22:0] != 23'd0);
    b_nan  = b_spec && (b[22:0] != 23'd0);
    if (a_nan || b_nan || (a_spec && b_spec && (a[31] != b[31]))) out = 32'h7FC00000;
    else if (a_spec)          out = a;
    else if (b_spec)          out = b;
    else if (a_zero && b_zero) out = {a[31] & b[31], 31'd0};
    else if (a_zero)          out = b;
    else if (b_zero)          out = a;
    else if (sum == 28'd0)    out = 32'd0;
    else if (e >= 255)        out = {big[31], 8'hFF, 23'd0};
    else if (e <= 0)          out = {big[31], 31'd0};
    else                      out = {big[31], e[7:0], frac};
  end

endmodule

// File: rtl/float_mult.sv
// IEEE-754 single multiply, round-to-nearest-even, subnormals flushed to zero.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module float_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [47:0] p;
  logic [25:0] n;
  logic [24:0] rm;
  logic [22:0] frac;
  logic        s, rnd, a_spec, b_spec, a_nan, b_nan, a_zero, b_zero;
  int          e;

  // Multiply mantissas, normalise by at most one place, round, then apply specials
  always_comb begin
    s      = a[31] ^ b[31];
    a_spec = (a[30:23] == 8'hFF);
    b_spec = (b[30:23] == 8'hFF);
    a_nan  = a_spec && (a[22:0] != 23'd0);
    b_nan  = b_spec && (b[22:0] != 23'd0);
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    p      = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (p[47]) begin
      n = {p[47:24], p[23], |p[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 126;
    end else begin
      n = {p[46:23], p[22], |p[21:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
    end
    rnd = n[1] & (n[0] | n[2]);
    rm  = {1'b0, n[25:2]} + 25'(rnd);
    if (rm[24]) begin
      e    = e + 1;
      frac = rm[23:1];
    end else begin
      frac = rm[22:0];
    end
    if (a_nan || b_nan || (a_spec && b_zero) || (b_spec && a_zero)) y = 32'h7FC00000;
    else if (a_spec || b_spec) y = {s, 8'hFF, 23'd0};
    else if (a_zero || b_zero) y = {s, 31'd0};
    else if (e >= 255)         y = {s, 8'hFF, 23'd0};
    else if (e <= 0)           y = {s, 31'd0};
    else                       y = {s, e[7:0], frac};
  end

endmodule

// File: rtl/node_mac_sequencer_weight_rom.sv
// Weight lookup for the MAC sequencer: activation index in, weight out.
// Latency: combinational.
// Backpressure: none.
module node_weight_rom
  import node_mac_sequencer_pkg::*;
#(
  parameter int N_INPUTS = 15,
  parameter int WIDTH    = 32,
  parameter int IW       = $clog2(N_INPUTS + 1)
) (
  input  logic [IW-1:0]    idx,
  output logic [WIDTH-1:0] weight
);

  assign weight = WIDTH'(weight_of(32'(idx)));

endmodule

// File: rtl/node_mac_sequencer.sv
// One neuron evaluation: ReLU(sum A[i]*W[i]) with a single shared multiplier and adder.
// Latency: N_INPUTS+2 cycles from start to out_valid with no input gaps.
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
module node_mac_sequencer
  import node_mac_sequencer_pkg::*;
#(
  parameter int N_INPUTS = 15,
  parameter int WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(N_INPUTS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, prod, weight, mul_res, add_res;
  logic             prod_vld, in_hs, out_hs;

  node_weight_rom #(.N_INPUTS(N_INPUTS), .WIDTH(WIDTH), .IW(CW)) u_rom (
    .idx    (count),
    .weight (weight)
  );

  float_mult u_mult (
    .a (in_data),
    .b (weight),
    .y (mul_res)
  );

  float_adder u_add (
    .a        (acc),
    .b        (prod),
    .out      (add_res),
    .Out_test (),
    .shift    (),
    .c_out    ()
  );

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, input acceptance and busy flag
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && count == LAST) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE:    if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Product pipeline, sequential accumulation and the held result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      acc       <= ZERO;
      prod      <= ZERO;
      prod_vld  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= ZERO;
    end else begin
      prod_vld <= in_hs;
      if (in_hs) begin
        prod  <= mul_res;
        count <= count + CW'(1);
      end
      if (state == IDLE && start) begin
        count <= '0;
        acc   <= ZERO;
      end else if (prod_vld) begin
        acc <= add_res;
      end
      if (state == DONE) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= relu(acc);
        end else if (out_ready) begin
          out_valid <= 1'b0;
          out_data  <= ZERO;
        end
      end
    end
  end

endmodule

// File: tb/tb_node_mac_sequencer.sv
// Bench for node_mac_sequencer: directed and random evaluations against a real-arithmetic model.
// Latency: checks out_valid timing of N_INPUTS+2 cycles when inputs are gap-free.
// Backpressure: exercises input gaps, output stalls and stray start pulses.
module tb_node_mac_sequencer;
  import node_mac_sequencer_pkg::*;

  localparam int N = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int nchecks = 0;
  int nerr    = 0;

  logic [31:0] act [N];
  logic [31:0] wt [16] = '{
    32'h3F000000, 32'h3F46BDCF, 32'hBF400000, 32'hBE7964A1,
    32'h3FC00000, 32'h3E800000, 32'hBF800000, 32'h3F59999A,
    32'h3DCCCCCD, 32'hC0000000, 32'h3F200000, 32'hBEAAAAAB,
    32'h3F800000, 32'h3E4CCCCD, 32'hBF000000, 32'h40400000
  };
  logic [31:0] pool [8] = '{
    32'h00000000, 32'h3F800000, 32'hBF800000, 32'h40000000,
    32'h3F000000, 32'h3FC00000, 32'hC0400000, 32'h80000000
  };

  node_mac_sequencer #(.N_INPUTS(N), .WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-precision bits to real (zero/subnormal read as signed zero).
  function automatic real s2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) d = {x[31], 63'd0};
    else d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Real to single-precision bits, round to nearest even (normal range only).
  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) m = m + 25'd1;
    if (m[24]) begin
      e = e + 1;
      m = m >> 1;
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  // Each product and each running sum rounded to single, in index order, then ReLU.
  function automatic logic [31:0] model_result();
    logic [31:0] acc, p;
    acc = 32'd0;
    for (int i = 0; i < N; i++) begin
      p   = r2s(s2r(act[i]) * s2r(wt[i % 16]));
      acc = r2s(s2r(acc) + s2r(p));
    end
    return acc[31] ? 32'd0 : acc;
  endfunction

  task automatic set_one_hot(input int idx);
    for (int i = 0; i < N; i++) act[i] = (i == idx) ? ONE : 32'd0;
  endtask

  task automatic run_eval(input string tag, input logic [31:0] exp, input int gap,
                          input int stall, input bit pulse, input bit chk_lat);
    int          edges;
    bit          seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    chk({tag, "/busy"}, 32'(busy), 32'd1);
    chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        tick();
        edges++;
      end
      in_valid = 1'b1;
      in_data  = act[i];
      if (pulse && i == 6) start = 1'b1;
      tick();
      edges++;
      start = 1'b0;
    end
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = (stall == 0);
    if (pulse) start = 1'b1;
    chk({tag, "/in_ready_drain"}, 32'(in_ready), 32'd0);
    seen = 1'b0;
    while (!seen && edges < 200) begin
      if (out_valid) seen = 1'b1;
      else begin
        tick();
        edges++;
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "/out_valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (chk_lat) chk({tag, "/latency"}, 32'(edges), 32'(N + 2));
      for (int s = 0; s < stall; s++) begin
        chk({tag, "/stall_data"}, out_data, exp);
        chk({tag, "/stall_ctl"}, {30'd0, out_valid, in_ready}, 32'd2);
        tick();
      end
      chk({tag, "/out_data"}, out_data, exp);
      out_ready = 1'b1;
      start = pulse;
      tick();
      start = 1'b0;
      out_ready = 1'b0;
      chk({tag, "/after_hs"}, {30'd0, out_valid, busy}, 32'd0);
      repeat (3) tick();
      chk({tag, "/stays_idle"}, {30'd0, out_valid, busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp;
    int          gap, stall;

    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    tick();
    rst_n = 1'b1;

    set_one_hot(-1);
    run_eval("all_zero", 32'h00000000, 0, 0, 1'b0, 1'b1);

    set_one_hot(1);
    run_eval("a1_one", 32'h3F46BDCF, 0, 0, 1'b0, 1'b1);

    set_one_hot(3);
    run_eval("a3_neg", 32'h00000000, 0, 0, 1'b0, 1'b1);

    set_one_hot(1);
    run_eval("gaps_stall", 32'h3F46BDCF, 3, 5, 1'b0, 1'b0);

    // Reset mid-evaluation after seven accepted activations.
    set_one_hot(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = act[i];
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    in_valid = 1'b0;
    in_data  = 32'd0;
    tick();
    rst_n = 1'b1;
    run_eval("after_reset", 32'h3F46BDCF, 0, 0, 1'b0, 1'b1);

    set_one_hot(1);
    run_eval("stray_start", 32'h3F46BDCF, 0, 0, 1'b1, 1'b1);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) act[i] = pool[$urandom_range(0, 7)];
      gap   = $urandom_range(0, 2);
      stall = $urandom_range(0, 3);
      exp   = model_result();
      run_eval($sformatf("rand%0d", t), exp, gap, stall, t[0], gap == 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
